// File: rtl/ts_null_stuffer.sv
// Packet-granular TS rate adapter: buffers whole 188-byte packets and replays them one byte per OUT_TICK, null packets fill gaps.
// Latency: output byte registered 1 cycle after its tick; no input backpressure, a packet arriving with all slots full is dropped whole.
module ts_null_stuffer #(
    parameter int PKT_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [7:0]                     DATA_IN,
    input  logic                           ENA_IN,
    input  logic                           PSYNC_IN,
    input  logic                           OUT_TICK,
    output logic [7:0]                     DATA_OUT,
    output logic                           ENA_OUT,
    output logic                           PSYNC_OUT,
    output logic [$clog2(PKT_DEPTH+1)-1:0] FILL,
    output logic [CNT_W-1:0]               OVF_CNT,
    output logic [CNT_W-1:0]               RUNT_CNT
);
    localparam int PKT_LEN = 188;
    localparam int SLOT_W  = $clog2(PKT_DEPTH);
    localparam int ADDR_W  = $clog2(PKT_DEPTH * PKT_LEN);
    localparam int FILL_W  = $clog2(PKT_DEPTH + 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_NULL} rstate_t;

    logic [7:0]        r_mem [PKT_DEPTH*PKT_LEN];
    logic [7:0]        r_ram_dat;
    wstate_t           r_wst, w_wst_nxt;
    rstate_t           r_rst_st, w_rst_nxt;
    logic [SLOT_W-1:0] r_wr_slot, r_rd_slot;
    logic [7:0]        r_wr_idx, w_wr_idx, w_wr_idx_nxt;
    logic [7:0]        r_rd_idx, w_rd_idx_nxt;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_ovf_cnt, r_runt_cnt;
    logic              r_ena_out, r_psync_out, r_out_ram;
    logic [7:0]        r_null_dat, w_null_byte;
    logic              w_sop, w_room, w_wr_en, w_commit, w_ovf_inc, w_runt_inc;
    logic              w_rd_en, w_release, w_emit_ram;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;

    assign w_sop     = ENA_IN & PSYNC_IN;
    assign w_room    = (r_fill < FILL_W'(PKT_DEPTH));
    assign w_wr_addr = ADDR_W'(r_wr_slot) * ADDR_W'(PKT_LEN) + ADDR_W'(w_wr_idx);
    assign w_rd_addr = ADDR_W'(r_rd_slot) * ADDR_W'(PKT_LEN) + ADDR_W'(r_rd_idx);

    // A slot is claimed at byte 0, so a commit can never find the buffer full.
    always_comb begin
        w_wst_nxt    = r_wst;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_wr_idx;
        w_wr_idx_nxt = r_wr_idx;
        w_commit     = 1'b0;
        w_ovf_inc    = 1'b0;
        w_runt_inc   = 1'b0;
        case (r_wst)
            W_IDLE, W_DROP: begin
                if (w_sop) begin
                    if (w_room) begin
                        w_wr_en      = 1'b1;
                        w_wr_idx     = 8'd0;
                        w_wr_idx_nxt = 8'd1;
                        w_wst_nxt    = W_FILL;
                    end else begin
                        w_ovf_inc = 1'b1;
                        w_wst_nxt = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (ENA_IN) begin
                    w_wr_en = 1'b1;
                    if (PSYNC_IN) begin
                        w_runt_inc   = 1'b1;
                        w_wr_idx     = 8'd0;
                        w_wr_idx_nxt = 8'd1;
                    end else if (r_wr_idx == 8'd187) begin
                        w_commit     = 1'b1;
                        w_wr_idx_nxt = 8'd0;
                        w_wst_nxt    = W_IDLE;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + 8'd1;
                    end
                end
            end
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    // The source is chosen only at a packet boundary; it then stays fixed for 188 ticks.
    always_comb begin
        w_rst_nxt    = r_rst_st;
        w_rd_idx_nxt = r_rd_idx;
        w_rd_en      = 1'b0;
        w_release    = 1'b0;
        w_emit_ram   = 1'b0;
        case (r_rd_idx)
            8'd0:    w_null_byte = 8'h47;
            8'd1:    w_null_byte = 8'h1F;
            8'd3:    w_null_byte = 8'h10;
            default: w_null_byte = 8'hFF;
        endcase
        if (OUT_TICK) begin
            case (r_rst_st)
                R_IDLE: begin
                    w_rd_idx_nxt = 8'd1;
                    if (r_fill != '0) begin
                        w_rst_nxt  = R_DATA;
                        w_rd_en    = 1'b1;
                        w_emit_ram = 1'b1;
                    end else begin
                        w_rst_nxt = R_NULL;
                    end
                end
                R_DATA, R_NULL: begin
                    w_rd_en    = (r_rst_st == R_DATA);
                    w_emit_ram = (r_rst_st == R_DATA);
                    if (r_rd_idx == 8'd187) begin
                        w_release    = (r_rst_st == R_DATA);
                        w_rd_idx_nxt = 8'd0;
                        w_rst_nxt    = R_IDLE;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + 8'd1;
                    end
                end
                default: w_rst_nxt = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem[w_wr_addr] <= DATA_IN;
        if (w_rd_en) r_ram_dat <= r_mem[w_rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wst       <= W_IDLE;
            r_rst_st    <= R_IDLE;
            r_wr_slot   <= '0;
            r_rd_slot   <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_fill      <= '0;
            r_ovf_cnt   <= '0;
            r_runt_cnt  <= '0;
            r_ena_out   <= 1'b0;
            r_psync_out <= 1'b0;
            r_out_ram   <= 1'b0;
            r_null_dat  <= '0;
        end else begin
            r_wst    <= w_wst_nxt;
            r_wr_idx <= w_wr_idx_nxt;
            r_rst_st <= w_rst_nxt;
            r_rd_idx <= w_rd_idx_nxt;
            if (w_commit)  r_wr_slot <= r_wr_slot + SLOT_W'(1);
            if (w_release) r_rd_slot <= r_rd_slot + SLOT_W'(1);
            case ({w_commit, w_release})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_ovf_inc && (r_ovf_cnt != {CNT_W{1'b1}}))   r_ovf_cnt  <= r_ovf_cnt + CNT_W'(1);
            if (w_runt_inc && (r_runt_cnt != {CNT_W{1'b1}})) r_runt_cnt <= r_runt_cnt + CNT_W'(1);
            r_ena_out   <= OUT_TICK;
            r_psync_out <= OUT_TICK && (r_rd_idx == 8'd0);
            if (OUT_TICK) begin
                r_out_ram  <= w_emit_ram;
                r_null_dat <= w_null_byte;
            end
        end
    end

    assign DATA_OUT  = r_out_ram ? r_ram_dat : r_null_dat;
    assign ENA_OUT   = r_ena_out;
    assign PSYNC_OUT = r_psync_out;
    assign FILL      = r_fill;
    assign OVF_CNT   = r_ovf_cnt;
    assign RUNT_CNT  = r_runt_cnt;
endmodule

// File: tb/tb_ts_null_stuffer.sv
// Bench for ts_null_stuffer: vector table, directed packet sequences, and a randomized packet-level scoreboard.
module tb_ts_null_stuffer;
    logic        CLK = 1'b0;
    logic        RST, ENA_IN, PSYNC_IN, OUT_TICK;
    logic [7:0]  DATA_IN, DATA_OUT;
    logic        ENA_OUT, PSYNC_OUT;
    logic [2:0]  FILL;
    logic [15:0] OVF_CNT, RUNT_CNT;

    ts_null_stuffer #(.PKT_DEPTH(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC_IN(PSYNC_IN),
        .OUT_TICK(OUT_TICK), .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC_OUT(PSYNC_OUT),
        .FILL(FILL), .OVF_CNT(OVF_CNT), .RUNT_CNT(RUNT_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0, n_align_bad = 0;
    logic tick_d = 1'b0;
    logic [8:0] q_out[$];   // {psync, data} of every byte seen with ENA_OUT
    int exp_ids[$];

    always @(posedge CLK) tick_d <= OUT_TICK & ~RST;
    always @(negedge CLK) begin
        if (ENA_OUT) q_out.push_back({PSYNC_OUT, DATA_OUT});
        if (ENA_OUT !== tick_d) n_align_bad++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] pkt_byte(input int id, input int i);
        case (i)
            0: return 8'h47;
            1: return 8'h40;
            2: return 8'h64;
            3: return 8'h10;
            default: return 8'(id * 7 + i);
        endcase
    endfunction

    function automatic logic [7:0] null_byte(input int i);
        case (i)
            0: return 8'h47;
            1: return 8'h1F;
            2: return 8'hFF;
            3: return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic step(input logic rst, input logic tk, input logic en, input logic ps, input logic [7:0] d);
        RST = rst; OUT_TICK = tk; ENA_IN = en; PSYNC_IN = ps; DATA_IN = d;
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        q_out.delete();
    endtask

    task automatic send_pkt(input int id);
        for (int i = 0; i < 188; i++) step(1'b0, 1'b0, 1'b1, i == 0, pkt_byte(id, i));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // id < 0 means a null packet is expected
    task automatic check_chunk(input string nm, input int id);
        int nbad = 0, first = -1;
        logic [8:0] got, want, fg = '0, fw = '0;
        if (q_out.size() < 188) begin
            chk({nm, " short"}, q_out.size(), 188);
            q_out.delete();
            return;
        end
        for (int i = 0; i < 188; i++) begin
            got  = q_out.pop_front();
            want = {i == 0, (id < 0) ? null_byte(i) : pkt_byte(id, i)};
            if (got !== want) begin
                nbad++;
                if (first < 0) begin first = i; fg = got; fw = want; end
            end
        end
        chk($sformatf("%s bad bytes (first b%0d {ps,dat}=%h want %h)", nm, first, fg, fw), nbad, 0);
    endtask

    task automatic sb_step();
        while (q_out.size() >= 188) begin
            if (q_out[1][7:0] == 8'h1F) check_chunk("rand null", -1);
            else if (exp_ids.size() > 0) check_chunk("rand data", exp_ids.pop_front());
            else begin
                chk("rand unexpected data packet", 1, 0);
                for (int i = 0; i < 188; i++) void'(q_out.pop_front());
            end
        end
    endtask

    typedef struct {
        logic       rst, tick;
        logic       ena, psync, chk_dat;
        logic [7:0] dat;
        logic [2:0] fill;
    } vec_t;
    vec_t tv[10];

    initial begin
        logic [8:0] in_q[$];
        int runt_exp, len;
        logic tk, en;
        logic [8:0] e;

        tv[0] = '{1, 0, 0, 0, 1, 8'h00, 0};
        tv[1] = '{0, 1, 1, 1, 1, 8'h47, 0};
        tv[2] = '{0, 0, 0, 0, 0, 8'h00, 0};
        tv[3] = '{0, 1, 1, 0, 1, 8'h1F, 0};
        tv[4] = '{0, 1, 1, 0, 1, 8'hFF, 0};
        tv[5] = '{0, 1, 1, 0, 1, 8'h10, 0};
        tv[6] = '{0, 1, 1, 0, 1, 8'hFF, 0};
        tv[7] = '{1, 1, 0, 0, 1, 8'h00, 0};
        tv[8] = '{0, 1, 1, 1, 1, 8'h47, 0};
        tv[9] = '{0, 1, 1, 0, 1, 8'h1F, 0};

        RST = 1'b1; OUT_TICK = 1'b0; ENA_IN = 1'b0; PSYNC_IN = 1'b0; DATA_IN = '0;
        @(negedge CLK);
        #1;
        for (int v = 0; v < 10; v++) begin
            step(tv[v].rst, tv[v].tick, 1'b0, 1'b0, 8'h00);
            chk($sformatf("vec%0d ENA_OUT", v), ENA_OUT, tv[v].ena);
            chk($sformatf("vec%0d PSYNC_OUT", v), PSYNC_OUT, tv[v].psync);
            if (tv[v].chk_dat) chk($sformatf("vec%0d DATA_OUT", v), DATA_OUT, tv[v].dat);
            chk($sformatf("vec%0d FILL", v), FILL, tv[v].fill);
        end
        chk("reset OVF_CNT", OVF_CNT, 0);
        chk("reset RUNT_CNT", RUNT_CNT, 0);

        // continuous nulls with a tick every 4 cycles
        do_reset();
        for (int c = 0; c < 376 * 4; c++) step(1'b0, c % 4 == 0, 1'b0, 1'b0, 8'h00);
        check_chunk("null stream pkt0", -1);
        check_chunk("null stream pkt1", -1);

        // packet committed while a null packet is in flight
        do_reset();
        for (int c = 0; c <= 375 * 4; c++) begin
            if (c == 160) chk("midnull FILL before", FILL, 0);
            if (c == 348) chk("midnull FILL after write", FILL, 1);
            if (c >= 160 && c < 348)
                step(1'b0, c % 4 == 0, 1'b1, c == 160, pkt_byte(1, c - 160));
            else
                step(1'b0, c % 4 == 0, 1'b0, 1'b0, 8'h00);
        end
        check_chunk("midnull first null", -1);
        check_chunk("midnull data", 1);
        chk("midnull FILL end", FILL, 0);

        // overflow: six packets into four slots, then counter saturation
        do_reset();
        for (int k = 0; k < 6; k++) send_pkt(80 + k);
        chk("ovf FILL", FILL, 4);
        chk("ovf OVF_CNT", OVF_CNT, 2);
        force dut.r_ovf_cnt = 16'hFFFD;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        release dut.r_ovf_cnt;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h47);
        chk("ovf saturation", OVF_CNT, 16'hFFFF);
        ticks(4 * 188);
        for (int k = 0; k < 4; k++) check_chunk($sformatf("ovf readout %0d", k), 80 + k);
        chk("ovf FILL drained", FILL, 0);

        // commit and release on the same edge
        do_reset();
        send_pkt(70);
        send_pkt(71);
        chk("cr FILL start", FILL, 2);
        for (int i = 0; i < 188; i++) begin
            if (i == 187) chk("cr FILL before edge", FILL, 2);
            step(1'b0, 1'b1, 1'b1, i == 0, pkt_byte(72, i));
        end
        chk("cr FILL same edge", FILL, 2);
        ticks(2 * 188);
        check_chunk("cr pkt70", 70);
        check_chunk("cr pkt71", 71);
        check_chunk("cr pkt72", 72);

        // runt: early PSYNC at byte 100
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, i == 0, pkt_byte(50, i));
        send_pkt(51);
        chk("runt RUNT_CNT", RUNT_CNT, 1);
        chk("runt FILL", FILL, 1);
        ticks(188);
        check_chunk("runt survivor", 51);
        chk("runt FILL end", FILL, 0);

        // reset during output of byte 50
        do_reset();
        send_pkt(60);
        ticks(51);
        chk("rst byte50 seen", q_out[50], {1'b0, pkt_byte(60, 50)});
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst ENA_OUT", ENA_OUT, 0);
        chk("rst DATA_OUT", DATA_OUT, 0);
        chk("rst PSYNC_OUT", PSYNC_OUT, 0);
        chk("rst FILL", FILL, 0);
        q_out.delete();
        ticks(188);
        check_chunk("rst then null", -1);

        // randomized traffic against a packet-level scoreboard
        do_reset();
        runt_exp = 0;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(3) == 0) begin
                len = $urandom_range(187, 1);
                for (int i = 0; i < len; i++) in_q.push_back({i == 0, (i == 0) ? 8'h47 : 8'($urandom)});
                runt_exp++;
            end
            for (int i = 0; i < 188; i++) in_q.push_back({i == 0, pkt_byte(100 + k, i)});
            exp_ids.push_back(100 + k);
        end
        while (in_q.size() > 0) begin
            tk = ($urandom_range(3) != 0);
            en = ($urandom_range(3) == 0);
            if (en) begin
                e = in_q.pop_front();
                step(1'b0, tk, 1'b1, e[8], e[7:0]);
            end else begin
                step(1'b0, tk, 1'b0, 1'b0, 8'h00);
            end
            sb_step();
        end
        for (int c = 0; c < 3000; c++) begin
            if (exp_ids.size() == 0 && q_out.size() == 0) break;
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            sb_step();
        end
        chk("rand packets left", exp_ids.size(), 0);
        chk("rand RUNT_CNT", RUNT_CNT, runt_exp);
        chk("rand OVF_CNT", OVF_CNT, 0);
        chk("rand FILL", FILL, 0);
        chk("ENA_OUT one cycle after tick", n_align_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
